seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 165 ++++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops, plus an optional
// shift-add multiplier that runs one multiplier bit per cycle. Results are held until the consumer accepts them.
module seq_alu #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             carry;
    logic             overflow;
  } alu_out_t;

  state_e             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  alu_out_t           alu;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     amt;
  logic               accept;
  logic               start_mul;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL);
  assign accept    = in_valid && in_ready;
  assign start_mul = MUL_EN && (alu_control == OP_MUL);

  // Single-cycle datapath. Shifts carry one guard bit so the last bit shifted
  // out lands in a fixed position, which also yields carry = 0 for amount 0.
  always_comb begin
    amt     = b[SHW-1:0];
    sum_ext = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    shl_ext = {1'b0, a} << amt;
    shr_ext = {a, 1'b0} >> amt;
    // NOTE: defaulting every always_comb output up front means no path leaves
    // a signal unassigned, so no latch is inferred.
    alu     = '0;
    case (op_e'(alu_control))
      OP_SUB: begin
        alu.value    = diff;
        alu.carry    = (a < b);
        alu.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: alu.value = a & b;
      OP_OR:  alu.value = a | b;
      OP_XOR: alu.value = a ^ b;
      OP_SHL: begin
        alu.value = shl_ext[WIDTH-1:0];
        alu.carry = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu.value = shr_ext[WIDTH:1];
        alu.carry = shr_ext[0];
      end
      default: begin
        // Add, and opcode 111 when the multiplier is not built.
        alu.value    = sum_ext[WIDTH-1:0];
        alu.carry    = sum_ext[WIDTH];
        alu.overflow = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
    endcase
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the multiply accumulator and counter are reset too, so an
      // aborted multiply can never leak partial products into a later result.
      state    <= IDLE;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_mul) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              result   <= alu.value;
              zero     <= (alu.value == '0);
              carry    <= alu.carry;
              negative <= alu.value[MSB];
              overflow <= alu.overflow;
              state    <= DONE;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The last bit's partial product is folded in on the same edge.
          if (cnt == SHW'(WIDTH - 1)) begin
            result   <= acc_next[WIDTH-1:0];
            zero     <= (acc_next[WIDTH-1:0] == '0);
            carry    <= |acc_next[2*WIDTH-1:WIDTH];
            negative <= acc_next[MSB];
            overflow <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16, MUL_EN=1): directed vectors push
// expected results; a monitor pops and compares on each output handshake.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        negative;
  logic        overflow;
  logic        busy;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    n_checks = 0;
  int    n_errors = 0;

  seq_alu #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .carry      (carry),
    .negative   (negative),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic v);
    exp_t e;
    e.res = r;
    e.z   = (r == 16'h0000);
    e.c   = c;
    e.n   = r[15];
    e.v   = v;
    return e;
  endfunction

  // Monitor: compares whenever the DUT hands over a result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        check({nm, "_result"}, result, e.res);
        check({nm, "_flags_zcnv"}, {zero, carry, negative, overflow}, {e.z, e.c, e.n, e.v});
      end
    end
  end

  // Issues one op from IDLE, then measures latency and busy cycles.
  task automatic do_op(input string name, input logic [2:0] op, input logic [15:0] x,
                       input logic [15:0] y, input exp_t e, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    a           = x;
    b           = y;
    alu_control = op;
    in_valid    = 1'b1;
    sb.push_back(e);
    sb_name.push_back(name);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (busy) busy_cnt++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, busy_cnt, (exp_lat == 1) ? 0 : exp_lat - 1);
  endtask

  initial begin
    int stray;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    alu_control = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {result, zero, carry, negative, overflow, busy}, '0);
    #21 rst_n = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);

    do_op("add_wrap",   3'b000, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 0), 1);
    do_op("sub_ovf",    3'b001, 16'h8000, 16'h0001, mk(16'h7FFF, 0, 1), 1);
    do_op("sub_borrow", 3'b001, 16'h0001, 16'h0002, mk(16'hFFFF, 1, 0), 1);
    do_op("sub_eq",     3'b001, 16'h0005, 16'h0005, mk(16'h0000, 0, 0), 1);
    do_op("add_ovf",    3'b000, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1), 1);
    do_op("mul_300",    3'b111, 16'd300,  16'd300,  mk(16'h5F90, 1, 0), 17);
    do_op("shl_1",      3'b101, 16'h8001, 16'h0011, mk(16'h0002, 1, 0), 1);
    do_op("shr_1",      3'b110, 16'h0001, 16'h0001, mk(16'h0000, 1, 0), 1);
    do_op("shl_0",      3'b101, 16'h1234, 16'h0010, mk(16'h1234, 0, 0), 1);
    do_op("shr_15",     3'b110, 16'h8000, 16'h000F, mk(16'h0001, 0, 0), 1);
    do_op("or",         3'b011, 16'h0F00, 16'h00F0, mk(16'h0FF0, 0, 0), 1);
    do_op("xor_zero",   3'b100, 16'hAAAA, 16'hAAAA, mk(16'h0000, 0, 0), 1);
    do_op("mul_small",  3'b111, 16'h0003, 16'h0005, mk(16'h000F, 0, 0), 17);

    // Back-pressure: hold an AND result, offer a competing op meanwhile.
    @(posedge clk);
    #1 out_ready = 1'b0;
    do_op("and_hold", 3'b010, 16'hF0F0, 16'hFF00, mk(16'hF000, 0, 0), 1);
    a           = 16'h0001;
    b           = 16'h0001;
    alu_control = 3'b000;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_state", {out_valid, in_ready, result, zero, carry, negative, overflow},
            {1'b1, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_release_idle", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    check("hold_no_queued_op", out_valid, 0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a           = 16'd300;
    b           = 16'd300;
    alu_control = 3'b111;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_mul_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {out_valid, busy, result, zero, carry, negative, overflow}, '0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("no_stale_out_valid", stray, 0);
    do_op("add_after_rst", 3'b000, 16'h0003, 16'h0004, mk(16'h0007, 0, 0), 1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
